btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Parametrised N-channel pushbutton front end; replaces per-button debounce/one_pulse instance pairs at top level.
- Per channel: 2-flop synchroniser, counter-based debounce, press/release one-cycle pulses, optional auto-repeat strobe for long holds (menu select, volume step).
- Feeds control and game logic directly; all outputs are registered.

Parameters:
- N_BTN, 5, number of independent button channels
- DB_CYCLES, 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz)
- REPEAT_DELAY, 50000000, cycles from press pulse to first repeat strobe (500 ms)
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat strobes (100 ms)
- CNT_W, derived localparam, $clog2 of the largest of the three counts plus 1; not user-set

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- btn_raw  in  N_BTN  asynchronous raw button inputs
- repeat_en  in  N_BTN  per-channel auto-repeat enable, sampled every cycle
- level  out  N_BTN  debounced button level
- press  out  N_BTN  1-cycle pulse on debounced 0->1
- release  out  N_BTN  1-cycle pulse on debounced 1->0
- strobe  out  N_BTN  press pulse OR auto-repeat pulse

Behaviour:
- Reset: on a clk edge with rst=1, all synchroniser flops, counters, FSMs and outputs go to 0 (level=0, press=release=strobe=0); this overrides everything, including reset mid-hold or mid-repeat.
- Synchroniser: btn_raw -> s1 -> s2; s2 is the only value used downstream.
- Debounce: if s2 == level, db_cnt <= 0. Otherwise db_cnt increments. When db_cnt == DB_CYCLES-1 and s2 still differs, level <= s2 and db_cnt <= 0.
  - Latency: a clean raw edge shows on level exactly 2+DB_CYCLES cycles later.
  - Any glitch shorter than DB_CYCLES cycles produces no level change.
- press and release are registered.
  - press is high only in the first cycle level reads 1.
  - release is high only in the first cycle level reads 0.
  - Neither can assert in the same cycle on one channel.
- Repeat FSM per channel, with states IDLE, WAIT, RPT and a counter rp_cnt:
  - IDLE -> WAIT on the press cycle, rp_cnt <= 0.
  - WAIT: rp_cnt increments each cycle. Exactly REPEAT_DELAY cycles after the press cycle, strobe pulses for 1 cycle, state -> RPT, rp_cnt <= 0.
  - RPT: strobe pulses every REPEAT_PERIOD cycles.
  - Any state -> IDLE when level==0 or repeat_en==0. No strobe fires in that cycle, and none fires until the next press.
  - repeat_en reasserted while held does not restart repeating.
- strobe = press OR repeat pulse. With repeat_en=0, strobe equals press.
- Channels are fully independent; simultaneous pulses on multiple channels are legal and expected.
- Button held through reset deassertion: level starts at 0, so a press is generated 2+DB_CYCLES cycles after rst falls.
- Counters saturate-free by construction: comparisons use ==, and widths come from CNT_W; no wrap occurs in normal use.
- Parameter constraints: DB_CYCLES >= 2, REPEAT_DELAY >= 2, REPEAT_PERIOD >= 2. Violations are flagged by an elaboration-time check.

Decomposition:
- Shared package (game_pkg): default timing constants DB_10MS, RPT_DELAY_500MS, RPT_PERIOD_100MS, CLK_HZ; repeat FSM state encoding (IDLE=2'd0, WAIT=2'd1, RPT=2'd2).
- One sub-module, btn_channel: a single channel containing the synchroniser, debounce, edge pulses and repeat FSM, with scalar ports. btn_conditioner is a generate loop of N_BTN btn_channel instances.

Test Plan (bench uses DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_BTN=5):
- Clean press: raw[0] 0->1 at cycle 0 and held, repeat_en=0 -> level[0] rises at cycle 6; press[0]=strobe[0]=1 only at cycle 6. Drop raw at cycle 30 -> release[0] at cycle 36, level[0]=0.
- Bounce: raw[1] toggles every 2 cycles for 20 cycles, then settles at 1 at cycle 20 -> exactly one press[1], at cycle 26; level[1] stays 0 before that.
- Auto-repeat: raw[2] held, repeat_en[2]=1, press at t=6 -> strobe[2] at 6, 16, 19, 22, 25. Release -> no strobe after the release cycle; release[2] pulses once.
- Repeat disable mid-hold: the same as above, but repeat_en[2] drops at cycle 20 -> strobes only at 6, 16, 19. Re-raising repeat_en while still held gives no further strobes.
- Independence: raw[3] and raw[4] pressed at cycles 0 and 1 -> press[3] at 6, press[4] at 7. Simultaneous raw edges on all 5 channels -> all press bits high in the same cycle.
- Reset mid-repeat: rst high for 1 cycle during RPT on channel 2, with raw still held -> all outputs 0 next cycle; new press[2] exactly 6 cycles after rst deasserts, repeat timing restarts from it.

Source files
------------

// File: rtl/game_pkg.sv
// Shared timing defaults and repeat-FSM encoding for the pushbutton front end.
// Values assume a 100 MHz clk.
package game_pkg;

  localparam int CLK_HZ           = 100_000_000;
  localparam int DB_10MS          = 1_000_000;
  localparam int RPT_DELAY_500MS  = 50_000_000;
  localparam int RPT_PERIOD_100MS = 10_000_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RPT  = 2'd2
  } rpt_state_e;

  // Counter width large enough to hold the biggest of the three counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One pushbutton channel: 2-flop synchroniser, counter debounce, registered
// press/release pulses and an auto-repeat strobe for long holds.
//
// state | meaning
// IDLE  | no repeat activity; waiting for a press with repeat enabled
// WAIT  | held since press; counting towards the first repeat strobe
// RPT   | repeating; one strobe every REPEAT_PERIOD cycles
module btn_channel
  import game_pkg::*;
#(
  parameter int DB_CYCLES     = DB_10MS,
  parameter int REPEAT_DELAY  = RPT_DELAY_500MS,
  parameter int REPEAT_PERIOD = RPT_PERIOD_100MS
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic strobe
);

  localparam int CNT_W = cnt_width(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  // The WAIT count starts the cycle after the press pulse, so the first
  // strobe decision lands one count earlier than REPEAT_DELAY-1.
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 2);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             strobe_q, strobe_d;
  rpt_state_e       state_q, state_d;
  logic [CNT_W-1:0] rp_cnt_q, rp_cnt_d;
  logic             rpt_fire;

  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_ONE;
      end
    end
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
    strobe_d  = press_d | rpt_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      strobe_q  <= strobe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rp_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rp_cnt_q <= rp_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rp_cnt_d = rp_cnt_q;
    if (!level_q || !repeat_en) begin
      state_d  = IDLE;
      rp_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_q) begin
            state_d  = WAIT;
            rp_cnt_d = '0;
          end
        end
        WAIT: begin
          if (rp_cnt_q == DLY_LAST) begin
            state_d  = RPT;
            rp_cnt_d = '0;
          end else begin
            rp_cnt_d = rp_cnt_q + CNT_ONE;
          end
        end
        RPT: begin
          if (rp_cnt_q == PER_LAST) begin
            rp_cnt_d = '0;
          end else begin
            rp_cnt_d = rp_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d  = IDLE;
          rp_cnt_d = '0;
        end
      endcase
    end
  end

  // Gated on the upcoming level so no repeat strobe lands on the release cycle.
  always_comb begin
    rpt_fire = 1'b0;
    if (level_q && level_d && repeat_en) begin
      if (state_q == WAIT && rp_cnt_q == DLY_LAST) begin
        rpt_fire = 1'b1;
      end else if (state_q == RPT && rp_cnt_q == PER_LAST) begin
        rpt_fire = 1'b1;
      end
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign strobe        = strobe_q;

endmodule

// File: rtl/btn_conditioner.sv
// N-channel pushbutton front end: one independent btn_channel per button,
// all outputs registered inside the channels.
module btn_conditioner
  import game_pkg::*;
#(
  parameter int N_BTN         = 5,
  parameter int DB_CYCLES     = DB_10MS,
  parameter int REPEAT_DELAY  = RPT_DELAY_500MS,
  parameter int REPEAT_PERIOD = RPT_PERIOD_100MS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] strobe
);

  if (DB_CYCLES < 2) begin : g_bad_db
    $error("btn_conditioner: DB_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY < 2) begin : g_bad_delay
    $error("btn_conditioner: REPEAT_DELAY must be >= 2");
  end
  if (REPEAT_PERIOD < 2) begin : g_bad_period
    $error("btn_conditioner: REPEAT_PERIOD must be >= 2");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .btn_raw       (btn_raw[i]),
      .repeat_en     (repeat_en[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .strobe        (strobe[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short timing constants; cycle c is
// the interval after the c-th clock edge following the reset release point.
module tb_btn_conditioner;

  localparam int N  = 5;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_raw   = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] level, press, release_pulse, strobe;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN         (N),
    .DB_CYCLES     (DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_raw       (btn_raw),
    .repeat_en     (repeat_en),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .strobe        (strobe)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int c, input logic [N-1:0] obs,
                       input logic [N-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int c, input logic [N-1:0] el,
                           input logic [N-1:0] ep, input logic [N-1:0] er,
                           input logic [N-1:0] es);
    check({tag, ".level"},   c, level,         el);
    check({tag, ".press"},   c, press,         ep);
    check({tag, ".release"}, c, release_pulse, er);
    check({tag, ".strobe"},  c, strobe,        es);
  endtask

  function automatic logic [N-1:0] bitv(input int ch, input bit v);
    logic [N-1:0] r;
    r = '0;
    r[ch] = v;
    return r;
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    btn_raw   = '0;
    repeat_en = '0;
    tick();
    tick();
    rst = 1'b0;
    check_all("reset", -1, '0, '0, '0, '0);
  endtask

  initial begin
    logic [N-1:0] el, ep, er, es;
    bit           s2;

    // Clean press and release on channel 0, no repeat.
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      btn_raw[0] = (c < 30);
      el = bitv(0, c >= 6 && c < 36);
      ep = bitv(0, c == 6);
      er = bitv(0, c == 36);
      check_all("clean", c, el, ep, er, ep);
      tick();
    end

    // Bouncing input on channel 1 settling high at cycle 20.
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      btn_raw[1] = (c < 20) ? (((c / 2) % 2) == 0) : 1'b1;
      el = bitv(1, c >= 26);
      ep = bitv(1, c == 26);
      check_all("bounce", c, el, ep, '0, ep);
      tick();
    end

    // Auto-repeat on channel 2, released so level falls on a would-be strobe cycle.
    do_reset();
    for (int c = 0; c <= 45; c++) begin
      btn_raw[2]   = (c < 28);
      repeat_en[2] = 1'b1;
      s2 = (c == 6) || (c >= 16 && c <= 31 && ((c - 16) % 3) == 0);
      el = bitv(2, c >= 6 && c < 34);
      ep = bitv(2, c == 6);
      er = bitv(2, c == 34);
      es = bitv(2, s2);
      check_all("repeat", c, el, ep, er, es);
      tick();
    end

    // Repeat enable dropped mid-hold, then raised again while still held.
    do_reset();
    for (int c = 0; c <= 45; c++) begin
      btn_raw[2]   = 1'b1;
      repeat_en[2] = (c < 20) || (c >= 30);
      s2 = (c == 6) || (c == 16) || (c == 19);
      el = bitv(2, c >= 6);
      ep = bitv(2, c == 6);
      es = bitv(2, s2);
      check_all("rpt_dis", c, el, ep, '0, es);
      tick();
    end

    // Staggered presses on channels 3 and 4.
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      btn_raw[3] = 1'b1;
      btn_raw[4] = (c >= 1);
      el = bitv(3, c >= 6) | bitv(4, c >= 7);
      ep = bitv(3, c == 6) | bitv(4, c == 7);
      check_all("indep", c, el, ep, '0, ep);
      tick();
    end

    // Simultaneous edges on every channel.
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      btn_raw = '1;
      el = (c >= 6) ? '1 : '0;
      ep = (c == 6) ? '1 : '0;
      check_all("simul", c, el, ep, '0, ep);
      tick();
    end

    // One-cycle reset during RPT with channel 2 still held.
    do_reset();
    for (int c = 0; c <= 45; c++) begin
      btn_raw[2]   = 1'b1;
      repeat_en[2] = 1'b1;
      rst          = (c == 20);
      s2 = (c == 6) || (c == 16) || (c == 19) || (c == 27) ||
           (c >= 37 && ((c - 37) % 3) == 0);
      el = bitv(2, (c >= 6 && c <= 20) || c >= 27);
      ep = bitv(2, c == 6 || c == 27);
      es = bitv(2, s2);
      check_all("rst_mid", c, el, ep, '0, es);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
